msrv_32_fetch_buffer: RTL and testbench

- Instruction fetch stage directly upstream of the instruction mux/decode stage.
- Owns the fetch PC and issues word requests on the instruction-memory req/ack bus.
- Buffers returned instructions in a small in-order queue and presents {instr, pc, valid} to decode.
- On branch/trap redirect, discards queued and in-flight fetches and emits a one-cycle flush that drives decode's flush_in.

---
 rtl/msrv_32_fetch_buffer.sv | 159 +++++++++++++++
 tb/tb_msrv_32_fetch_buffer.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/msrv_32_fetch_buffer.sv
// Instruction fetch stage: owns the fetch PC, issues word requests under a credit limit,
// and buffers returned words in an in-order queue whose head is registered toward decode.
module msrv_32_fetch_buffer #(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int          DEPTH     = 4
) (
  input  logic        ms_riscv32_mp_clk_in,
  input  logic        ms_riscv32_mp_rst_in,
  output logic [31:0] ms_riscv32_mp_imaddr_out,
  output logic        ms_riscv32_mp_imreq_out,
  input  logic        ms_riscv32_mp_imack_in,
  input  logic        ms_riscv32_mp_instr_valid_in,
  input  logic [31:0] ms_risc32_mp_instr_in,
  input  logic        redirect_in,
  input  logic [31:0] redirect_pc_in,
  input  logic        stall_in,
  output logic [31:0] instr_out,
  output logic [31:0] pc_out,
  output logic        valid_out,
  output logic        flush_out
);

  localparam int          PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int          CW      = PW + 1;
  localparam int          SW      = CW + 1;
  localparam logic [31:0] NOP     = 32'h0000_0013;
  localparam logic [31:0] BOOT_PC = {BOOT_ADDR[31:2], 2'b00};

  logic          started_q;
  logic [31:0]   fetch_pc_q, fetch_pc_d;
  logic [31:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] occ_q, occ_d;
  logic [CW-1:0] outst_q, outst_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   pc_q, pc_d;
  logic          valid_q, valid_d;
  logic          flush_q, flush_d;

  logic [31:0]   mem_instr_q [DEPTH];
  logic [31:0]   mem_pc_q    [DEPTH];

  logic          credit_ok;
  logic          req;
  logic          accept;
  logic          resp_ok;
  logic          drop_resp;
  logic          push;
  logic          pop;
  logic [CW-1:0] avail;
  logic [31:0]   redirect_target;
  logic          unused_pc_bits;

  assign unused_pc_bits  = ^redirect_pc_in[1:0];
  assign redirect_target = {redirect_pc_in[31:2], 2'b00};

  // Dropped fetches stay in outst_q until they return, so they keep holding credit.
  assign credit_ok = ({1'b0, occ_q} + {1'b0, outst_q}) < SW'(DEPTH);
  assign req       = started_q && !redirect_in && credit_ok;
  assign accept    = req && ms_riscv32_mp_imack_in;
  assign resp_ok   = ms_riscv32_mp_instr_valid_in && (outst_q != '0);
  assign drop_resp = resp_ok && (drop_q != '0);
  assign push      = resp_ok && (drop_q == '0) && !redirect_in;
  assign pop       = valid_q && !stall_in && !redirect_in;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    occ_d      = occ_q;
    outst_d    = outst_q + CW'(accept) - CW'(resp_ok);
    drop_d     = drop_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    instr_d    = instr_q;
    pc_d       = pc_q;
    valid_d    = valid_q;
    flush_d    = 1'b0;
    avail      = occ_q - CW'(pop);

    if (accept) begin
      fetch_pc_d = fetch_pc_q + 32'd4;
    end

    if (redirect_in) begin
      fetch_pc_d = redirect_target;
      resp_pc_d  = redirect_target;
      occ_d      = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      drop_d     = drop_q + outst_q - CW'(resp_ok);
      valid_d    = 1'b0;
      instr_d    = NOP;
      flush_d    = 1'b1;
    end else begin
      drop_d = drop_q - CW'(drop_resp);
      if (push) begin
        wr_ptr_d  = wr_ptr_q + PW'(1);
        resp_pc_d = resp_pc_q + 32'd4;
      end
      rd_ptr_d = rd_ptr_q + PW'(pop);
      occ_d    = occ_q - CW'(pop) + CW'(push);
      // Output loads from pre-edge contents only: a word pushed this edge shows next edge.
      valid_d  = (avail != '0);
      if (valid_d) begin
        instr_d = mem_instr_q[rd_ptr_d];
        pc_d    = mem_pc_q[rd_ptr_d];
      end else begin
        instr_d = NOP;
      end
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in or negedge ms_riscv32_mp_rst_in) begin
    if (!ms_riscv32_mp_rst_in) begin
      started_q  <= 1'b0;
      fetch_pc_q <= BOOT_PC;
      resp_pc_q  <= BOOT_PC;
      occ_q      <= '0;
      outst_q    <= '0;
      drop_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      instr_q    <= NOP;
      pc_q       <= '0;
      valid_q    <= 1'b0;
      flush_q    <= 1'b0;
    end else begin
      started_q  <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      occ_q      <= occ_d;
      outst_q    <= outst_d;
      drop_q     <= drop_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      instr_q    <= instr_d;
      pc_q       <= pc_d;
      valid_q    <= valid_d;
      flush_q    <= flush_d;
    end
  end

  always_ff @(posedge ms_riscv32_mp_clk_in) begin
    if (push) begin
      mem_instr_q[wr_ptr_q] <= ms_risc32_mp_instr_in;
      mem_pc_q[wr_ptr_q]    <= resp_pc_q;
    end
  end

  assign ms_riscv32_mp_imaddr_out = fetch_pc_q;
  assign ms_riscv32_mp_imreq_out  = req;
  assign instr_out                = instr_q;
  assign pc_out                   = pc_q;
  assign valid_out                = valid_q && !flush_q;
  assign flush_out                = flush_q;

endmodule

// File: tb/tb_msrv_32_fetch_buffer.sv
// Scoreboard bench for msrv_32_fetch_buffer: a memory model answers fetches, directed
// phases queue the expected PCs, and a negedge monitor checks every consumed output.
module tb_msrv_32_fetch_buffer;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imaddr;
  logic        imreq;
  logic        imack;
  logic        mem_rv;
  logic        stray_rv;
  logic        instr_valid;
  logic [31:0] mem_data;
  logic [31:0] instr_in;
  logic        redirect;
  logic [31:0] rpc;
  logic        stall;
  logic [31:0] instr_out;
  logic [31:0] pc_out;
  logic        valid_out;
  logic        flush_out;

  assign instr_valid = mem_rv | stray_rv;
  assign instr_in    = stray_rv ? 32'hDEAD_BEEF : mem_data;

  always #5 clk = ~clk;

  msrv_32_fetch_buffer dut (
    .ms_riscv32_mp_clk_in         (clk),
    .ms_riscv32_mp_rst_in         (rst_n),
    .ms_riscv32_mp_imaddr_out     (imaddr),
    .ms_riscv32_mp_imreq_out      (imreq),
    .ms_riscv32_mp_imack_in       (imack),
    .ms_riscv32_mp_instr_valid_in (instr_valid),
    .ms_risc32_mp_instr_in        (instr_in),
    .redirect_in                  (redirect),
    .redirect_pc_in               (rpc),
    .stall_in                     (stall),
    .instr_out                    (instr_out),
    .pc_out                       (pc_out),
    .valid_out                    (valid_out),
    .flush_out                    (flush_out)
  );

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          consumed = 0;
  int          first_valid_edge = -1;
  int          wait_states = 0;
  int          resp_budget = -1;
  logic [31:0] exp_q [$];
  logic [31:0] acc_log [$];
  int          acc_edge [$];
  int          cons_edge [$];
  logic [31:0] mon_e;

  always @(posedge clk) cyc = cyc + 1;

  function automatic logic [31:0] f_instr(input logic [31:0] pc);
    return {pc[13:0], 18'h0} ^ NOP;
  endfunction

  function automatic logic [31:0] acc_at(input int i);
    return (i < acc_log.size()) ? acc_log[i] : 32'hFFFF_FFFF;
  endfunction

  function automatic int edge_at(input int i);
    return (i < acc_edge.size()) ? acc_edge[i] : -1000;
  endfunction

  function automatic int cons_at(input int i);
    return (i < cons_edge.size()) ? cons_edge[i] : -1000;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkint(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [31:0] base, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
  endtask

  task automatic wait_consumed(input int n, input int limit, input string name);
    int k = 0;
    while (consumed < n && k < limit) begin
      tick();
      k++;
    end
    checks++;
    if (consumed < n) begin
      errors++;
      $display("FAIL %s: consumed %0d expected %0d within %0d cycles", name, consumed, n, limit);
    end
  endtask

  task automatic wait_acc(input int n, input int limit, input string name);
    int k = 0;
    while (acc_log.size() < n && k < limit) begin
      tick();
      k++;
    end
    checks++;
    if (acc_log.size() < n) begin
      errors++;
      $display("FAIL %s: accepted %0d expected %0d within %0d cycles", name, acc_log.size(), n, limit);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    exp_q.delete();
    acc_log.delete();
    acc_edge.delete();
    cons_edge.delete();
    consumed         = 0;
    first_valid_edge = -1;
    redirect         = 1'b0;
    stall            = 1'b0;
    stray_rv         = 1'b0;
    repeat (2) tick();
  endtask

  // Memory model: acks after wait_states unacked request cycles, answers one cycle after accept.
  initial begin : memory
    int          wait_cnt;
    logic        hold_valid;
    logic [31:0] hold_addr;
    logic [31:0] pend [$];
    wait_cnt   = 0;
    hold_valid = 1'b0;
    hold_addr  = '0;
    imack      = 1'b0;
    mem_rv     = 1'b0;
    mem_data   = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_rv = 1'b0;
      if (rst_n === 1'b1 && pend.size() > 0 && resp_budget != 0) begin
        mem_rv   = 1'b1;
        mem_data = f_instr(pend.pop_front());
        if (resp_budget > 0) resp_budget--;
      end
      imack = (wait_cnt >= wait_states);
      @(negedge clk);
      if (rst_n !== 1'b1) begin
        pend.delete();
        wait_cnt   = 0;
        hold_valid = 1'b0;
      end else if (imreq === 1'b1) begin
        if (imack) begin
          pend.push_back(imaddr);
          acc_log.push_back(imaddr);
          acc_edge.push_back(cyc + 1);
          wait_cnt   = 0;
          hold_valid = 1'b0;
        end else begin
          if (hold_valid) check32("addr_stable_while_waiting", imaddr, hold_addr);
          hold_addr  = imaddr;
          hold_valid = 1'b1;
          wait_cnt++;
        end
      end else begin
        hold_valid = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (valid_out === 1'b1 && first_valid_edge < 0) first_valid_edge = cyc;
      if (valid_out === 1'b1 && stall === 1'b0 && redirect === 1'b0) begin
        cons_edge.push_back(cyc);
        consumed++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: pc %h instr %h with empty scoreboard", pc_out, instr_out);
        end else begin
          mon_e = exp_q.pop_front();
          check32("sb_pc", pc_out, mon_e);
          check32("sb_instr", instr_out, f_instr(mon_e));
        end
      end
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int          c0;
    logic [31:0] held_pc;
    rst_n    = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    rpc      = '0;
    stray_rv = 1'b0;
    repeat (3) tick();

    // Reset values
    check32("rst_valid", {31'b0, valid_out}, 32'd0);
    check32("rst_instr", instr_out, NOP);
    check32("rst_pc", pc_out, 32'd0);
    check32("rst_flush", {31'b0, flush_out}, 32'd0);
    check32("rst_imreq", {31'b0, imreq}, 32'd0);

    // Streaming from boot with a 1-cycle memory
    push_exp(32'h0, 64);
    rst_n = 1'b1;
    wait_consumed(10, 60, "t1_flow");
    check32("t1_addr0", acc_at(0), 32'h0);
    check32("t1_addr1", acc_at(1), 32'h4);
    check32("t1_addr2", acc_at(2), 32'h8);
    checkint("t1_addr_consecutive", edge_at(2) - edge_at(0), 2);
    checkint("t1_first_valid_latency", first_valid_edge - edge_at(0), 2);
    checkint("t1_throughput", cons_at(9) - cons_at(0), 9);

    // Stall: queue fills, requests stop, outputs hold
    stall = 1'b1;
    check32("t2_valid_at_stall", {31'b0, valid_out}, 32'd1);
    held_pc = pc_out;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check32("t2_pc_held", pc_out, held_pc);
    end
    check32("t2_imreq_full", {31'b0, imreq}, 32'd0);
    check32("t2_valid_held", {31'b0, valid_out}, 32'd1);
    tick();
    stall = 1'b0;
    c0 = consumed;
    wait_consumed(c0 + 8, 40, "t2_drain");

    // Redirect with 2 queued and 2 in flight
    do_reset();
    stall       = 1'b1;
    resp_budget = 2;
    rst_n       = 1'b1;
    wait_acc(4, 20, "t3_fill");
    tick();
    tick();
    check32("t3_imreq_full", {31'b0, imreq}, 32'd0);
    check32("t3_valid_before", {31'b0, valid_out}, 32'd1);
    check32("t3_pc_before", pc_out, 32'h0);
    redirect = 1'b1;
    rpc      = 32'h0000_0102;
    exp_q.delete();
    push_exp(32'h100, 32);
    acc_log.delete();
    acc_edge.delete();
    tick();
    redirect    = 1'b0;
    stall       = 1'b0;
    resp_budget = -1;
    @(negedge clk);
    check32("t3_flush_high", {31'b0, flush_out}, 32'd1);
    check32("t3_valid_in_flush", {31'b0, valid_out}, 32'd0);
    tick();
    @(negedge clk);
    check32("t3_flush_one_cycle", {31'b0, flush_out}, 32'd0);
    check32("t3_queue_empty", {31'b0, valid_out}, 32'd0);
    wait_acc(1, 20, "t3_refetch");
    check32("t3_refetch_addr", acc_at(0), 32'h100);
    c0 = consumed;
    wait_consumed(c0 + 6, 40, "t3_after_redirect");

    // Redirect coinciding with a response and a pop
    do_reset();
    push_exp(32'h0, 64);
    rst_n = 1'b1;
    wait_consumed(6, 40, "t4_flow");
    redirect = 1'b1;
    rpc      = 32'h0000_0203;
    exp_q.delete();
    push_exp(32'h200, 32);
    @(negedge clk);
    check32("t4_pop_and_resp", {31'b0, valid_out && instr_valid}, 32'd1);
    tick();
    redirect = 1'b0;
    @(negedge clk);
    check32("t4_valid_after", {31'b0, valid_out}, 32'd0);
    check32("t4_flush_after", {31'b0, flush_out}, 32'd1);
    c0 = consumed;
    wait_consumed(c0 + 6, 40, "t4_after_redirect");

    // Memory with 3 wait states
    do_reset();
    wait_states = 3;
    push_exp(32'h0, 32);
    rst_n = 1'b1;
    wait_consumed(5, 150, "t5_flow");
    checkint("t5_ack_spacing", edge_at(1) - edge_at(0), 4);
    check32("t5_addr1", acc_at(1), 32'h4);
    wait_states = 0;

    // Async reset with 3 in flight, then stray responses
    do_reset();
    stall       = 1'b1;
    resp_budget = 1;
    rst_n       = 1'b1;
    wait_acc(4, 20, "t6_fill");
    tick();
    check32("t6_valid_before", {31'b0, valid_out}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check32("t6_rst_valid", {31'b0, valid_out}, 32'd0);
    check32("t6_rst_instr", instr_out, NOP);
    check32("t6_rst_pc", pc_out, 32'd0);
    check32("t6_rst_flush", {31'b0, flush_out}, 32'd0);
    check32("t6_rst_imreq", {31'b0, imreq}, 32'd0);
    do_reset();
    resp_budget = -1;
    push_exp(32'h0, 32);
    rst_n    = 1'b1;
    stray_rv = 1'b1;
    tick();
    tick();
    stray_rv = 1'b0;
    wait_acc(1, 20, "t6_restart");
    check32("t6_boot_addr", acc_at(0), 32'h0);
    wait_consumed(6, 40, "t6_flow");

    repeat (3) tick();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
